sort4_serializer: RTL and testbench

SORT4_SERIALIZER -- requirements
Module: sort4_serializer

---
 rtl/sort4_serializer.sv | 56 +++++
 tb/tb_sort4_serializer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sort4_serializer.sv
// sort4_serializer: buffers sorted 4-byte frames in a FIFO and streams them out one byte per transfer
module sort4_serializer #(
  parameter int DEPTH   = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_d0,
  input  logic [7:0]               in_d1,
  input  logic [7:0]               in_d2,
  input  logic [7:0]               in_d3,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [1:0]    bcnt, sel;
  logic [31:0]   head;
  logic          xfer, pop, push, full;
  // handshake decode and byte selection from the head frame; a pop frees a slot for a same-cycle push
  always_comb begin
    out_valid = level != '0;
    full      = level == (AW+1)'(DEPTH);
    xfer      = out_valid & out_ready;
    out_last  = out_valid & (bcnt == 2'd3);
    pop       = xfer & out_last;
    push      = in_valid & (~full | pop);
    head      = mem[rptr];
    sel       = DESCEND ? ~bcnt : bcnt;
    out_data  = out_valid ? head[{sel, 3'b000} +: 8] : 8'h00;
  end
  // frame storage needs no reset; out_data is masked while empty
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {in_d3, in_d2, in_d1, in_d0};
  // pointers, occupancy, byte counter and sticky drop flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      bcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (xfer) bcnt <= bcnt + 2'd1;
      level    <= level + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= overflow | (in_valid & full & ~pop);
    end
endmodule

// File: tb/tb_sort4_serializer.sv
// tb_sort4_serializer: randomized and directed checks of both byte orders against a frame-queue model
module tb_sort4_serializer;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_d0 = '0, in_d1 = '0, in_d2 = '0, in_d3 = '0;
  logic [7:0] a_data, d_data;
  logic       a_valid, d_valid, a_last, d_last, a_ovf, d_ovf;
  logic [2:0] a_level, d_level;
  int         vectors = 0, miscompares = 0;
  logic [31:0] fq[$];
  int         pos = 0;
  bit         ovf = 1'b0;

  always #5 clk = ~clk;

  sort4_serializer #(.DEPTH(4), .DESCEND(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
    .out_last(a_last), .level(a_level), .overflow(a_ovf));

  sort4_serializer #(.DEPTH(4), .DESCEND(1'b1)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
    .out_data(d_data), .out_valid(d_valid), .out_ready(out_ready),
    .out_last(d_last), .level(d_level), .overflow(d_ovf));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_frame();
    logic [7:0] b [4];
    b[0] = 8'($urandom_range(255, 0));
    for (int i = 1; i < 4; i++) b[i] = 8'($urandom_range(255, int'(b[i-1])));
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic check_outputs();
    bit         ne = fq.size() > 0;
    logic [7:0] ea = ne ? fq[0][8*pos +: 8] : 8'h00;
    logic [7:0] ed = ne ? fq[0][8*(3-pos) +: 8] : 8'h00;
    chk("valid_a", 32'(a_valid), 32'(ne));
    chk("valid_d", 32'(d_valid), 32'(ne));
    chk("data_a", 32'(a_data), 32'(ea));
    chk("data_d", 32'(d_data), 32'(ed));
    chk("last_a", 32'(a_last), 32'(ne && pos == 3));
    chk("last_d", 32'(d_last), 32'(ne && pos == 3));
    chk("level", 32'(a_level), fq.size());
    chk("level_d", 32'(d_level), fq.size());
    chk("overflow", 32'(a_ovf), 32'(ovf));
    chk("overflow_d", 32'(d_ovf), 32'(ovf));
  endtask

  // one clock cycle: drive, check at negedge, advance the model at posedge
  task automatic step(input bit iv, input logic [31:0] f, input bit rdy);
    bit ne, xfer, pop, full;
    in_valid  = iv;
    {in_d3, in_d2, in_d1, in_d0} = iv ? f : 32'($urandom);
    out_ready = rdy;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    ne   = fq.size() > 0;
    xfer = ne && rdy;
    pop  = xfer && pos == 3;
    full = fq.size() == 4;
    if (xfer) pos = pop ? 0 : pos + 1;
    if (pop) void'(fq.pop_front());
    if (iv && (!full || pop)) fq.push_back(f);
    if (iv && full && !pop) ovf = 1'b1;
    #1;
  endtask

  task automatic mid_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    fq.delete();
    pos = 0;
    ovf = 1'b0;
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_level", 32'(a_level), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    chk("rst_data", 32'(a_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", 32'(a_valid), 0);
    chk("init_last", 32'(a_last), 0);
    chk("init_data", 32'(a_data), 0);
    chk("init_level", 32'(a_level), 0);
    chk("init_ovf", 32'(a_ovf), 0);
    rst = 1'b0;
    // basic single frame, always ready
    step(1, 32'hF03C1A05, 1);
    repeat (5) step(0, 0, 1);
    // back-pressure after the first byte
    step(1, 32'hF03C1A05, 1);
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    repeat (4) step(0, 0, 1);
    // fill, then push exactly on the head frame's last transfer, then overflow
    for (int i = 0; i < 4; i++) step(1, rand_frame(), 0);
    repeat (3) step(0, 0, 1);
    step(1, rand_frame(), 1);
    step(1, rand_frame(), 0);
    step(0, 0, 0);
    chk("full_level", 32'(a_level), 4);
    chk("full_ovf", 32'(a_ovf), 1);
    repeat (20) step(0, 0, 1);
    // reset after two bytes of a frame
    mid_reset();
    step(1, 32'h04030201, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    mid_reset();
    step(1, 32'h04030201, 1);
    repeat (5) step(0, 0, 1);
    // continuous stream, one frame every fourth cycle
    for (int i = 0; i < 100; i++) begin
      step(1, rand_frame(), 1);
      chk("stream_lvl_le2", 32'(a_level <= 3'd2), 1);
      repeat (3) begin
        step(0, 0, 1);
        chk("stream_lvl_le2", 32'(a_level <= 3'd2), 1);
      end
    end
    repeat (4) step(0, 0, 1);
    chk("stream_ovf", 32'(a_ovf), 0);
    // random traffic
    mid_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(2, 0) == 0, rand_frame(), $urandom_range(1, 0) == 1);
    repeat (20) step(0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
